mask_share_gen: RTL
===================

MASK_SHARE_GEN -- requirements
Module: mask_share_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width; it matches the share width of the masked ripple-carry adder it feeds.
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value; it must be non-zero.
REQ-003 The block SHALL have parameter REFRESH, default 8, giving the idle-hold cycles before share re-randomisation; 0 disables refresh.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: upstream offers a, b.
REQ-007 Port in_ready, output, 1 bit: block accepts a, b this cycle.
REQ-008 Port a, input, WIDTH bits: plaintext operand A.
REQ-009 Port b, input, WIDTH bits: plaintext operand B.
REQ-010 Port seed_load, input, 1 bit: load seed into the LFSR.
REQ-011 Port seed, input, 16 bits: new LFSR value.
REQ-012 Port out_valid, output, 1 bit: shares are presented to the adder.
REQ-013 Port out_ready, input, 1 bit: the downstream stage takes the shares.
REQ-014 Ports a0, a1, b0, b1, outputs, WIDTH bits each: Boolean shares, with a = a0^a1 and b = b0^b1.

Function
REQ-015 LFSR behaviour SHALL be:
- 16-bit Galois LFSR, mask 16'hB400.
- next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Advances every cycle unless rst or seed_load is high.
REQ-016 When seed_load=1, next lfsr SHALL be seed; if seed==0, next lfsr SHALL be SEED instead (the all-zero state is never entered).
REQ-017 The FSM SHALL have two states:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
REQ-018 in_ready SHALL be combinational: in_ready = (state==EMPTY) || out_ready.
REQ-019 Accept SHALL be in_valid && in_ready; on accept, the next-edge register values SHALL be:
- ma = lfsr[3:0], mb = lfsr[7:4] (current-cycle lfsr).
- a0 = a^ma, a1 = ma, b0 = b^mb, b1 = mb.
- state becomes FULL.
REQ-020 Latency SHALL be one cycle: shares become valid on the edge following accept.
REQ-021 FULL with out_ready=1 and no accept SHALL give next state EMPTY; the share registers hold their values.
REQ-022 FULL with out_ready=1 and in_valid=1 SHALL be a simultaneous take and accept: the state stays FULL, new shares load, and full throughput is one operand pair per cycle.
REQ-023 While FULL and out_ready=0, in_valid SHALL be ignored and a, b SHALL NOT be sampled.
REQ-024 Refresh counter rcnt (width clog2(REFRESH)+1) SHALL behave as follows:
- Cleared on accept and on entering EMPTY.
- Increments each FULL cycle with out_ready=0.
REQ-025 When REFRESH>0, FULL, out_ready=0 and rcnt==REFRESH-1, the next edge SHALL apply ra = lfsr[11:8], rb = lfsr[15:12], and clear rcnt:
- a0 ^= ra, a1 ^= ra.
- b0 ^= rb, b1 ^= rb.
REQ-026 Refresh SHALL preserve a0^a1 and b0^b1 exactly; individual shares may change while out_valid=1, but recombined values never do.
REQ-027 Refresh SHALL NOT occur on a cycle where out_ready=1.
REQ-028 No output SHALL depend combinationally on a or b; all share outputs are registered.
REQ-029 Plaintext a, b SHALL never be stored unmasked in any register.

Reset
REQ-030 On rst=1 at an edge, the following SHALL apply, regardless of operation in flight:
- state = EMPTY, out_valid = 0.
- a0 = a1 = b0 = b1 = 0.
- rcnt = 0, lfsr = SEED.
REQ-031 rst SHALL take priority over seed_load, accept and refresh; an in-flight pair is discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 Reset, then a=4'h5, b=4'hA, in_valid=1 in the first cycle (lfsr=16'hACE1) -> next cycle out_valid=1, a0=4'h4, a1=4'h1, b0=4'h4, b1=4'hE.
REQ-034 Free-run after reset -> lfsr sequence 16'hACE1, 16'hE270, 16'h7138; seed_load with seed=0 -> lfsr=16'hACE1 next cycle.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 16 cycles with a=i, b=15-i -> one output per cycle, a0^a1=i, b0^b1=15-i, sum from the downstream adder = 15 every pair.
REQ-036 Back-pressure: out_ready=0 for 20 cycles, REFRESH=8 -> in_ready=0 throughout; shares change exactly at hold cycles 8 and 16; a0^a1 and b0^b1 are constant.
REQ-037 Assert rst while FULL with out_ready=0 -> next cycle out_valid=0, shares=0, in_ready=1; the pending pair is never delivered.
REQ-038 Random run of 10k cycles with random valid/ready -> scoreboard matches in order with no loss or duplication; a1 and b1 are never constant over 100 consecutive accepts.

Source files
------------

// File: rtl/mask_share_gen.sv
// Splits plaintext operands a, b into two Boolean shares each, masks drawn from a 16-bit Galois LFSR.
// Latency: shares are valid one cycle after accept; streams one operand pair per cycle.
// Backpressure: a single output stage; in_ready drops while full and out_ready=0, and idle held shares are periodically re-masked.
module mask_share_gen #(
    parameter int          WIDTH   = 4,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          REFRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1
);

    // Output stage occupancy.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Refresh counter sizing; REFRESH=0 still yields a legal 1-bit counter.
    localparam int             RW    = $clog2(REFRESH) + 1;
    localparam logic [RW-1:0]  RLAST = RW'((REFRESH > 0) ? (REFRESH - 1) : 0);

    logic [0:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_step;
    logic [RW-1:0]    rcnt;
    logic             accept;
    logic             take;
    logic             hold;
    logic             refresh_hit;

    // Masks are sliced from the LFSR as four WIDTH-bit fields (WIDTH up to 4 fits in 16 bits):
    // the low two fields mask new operands, the high two re-mask held shares.
    logic [WIDTH-1:0] ma, mb, ra, rb;

    assign ma = lfsr[WIDTH-1:0];
    assign mb = lfsr[2*WIDTH-1:WIDTH];
    assign ra = lfsr[3*WIDTH-1:2*WIDTH];
    assign rb = lfsr[4*WIDTH-1:3*WIDTH];

    assign lfsr_step   = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign in_ready    = (state == EMPTY) || out_ready;
    assign out_valid   = (state == FULL);
    assign accept      = in_valid && in_ready;
    assign take        = (state == FULL) && out_ready;
    assign hold        = (state == FULL) && !out_ready;
    assign refresh_hit = (REFRESH > 0) && hold && (rcnt == RLAST);

    // LFSR free-runs; a zero seed would lock it up, so it falls back to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? SEED : seed;
        end else begin
            lfsr <= lfsr_step;
        end
    end

    // Output stage: load masked shares on accept, empty on take, re-mask while held.
    // Plaintext only ever lands in a register already XORed with a fresh mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            rcnt  <= '0;
            a0    <= '0;
            a1    <= '0;
            b0    <= '0;
            b1    <= '0;
        end else if (accept) begin
            state <= FULL;
            rcnt  <= '0;
            a0    <= a ^ ma;
            a1    <= ma;
            b0    <= b ^ mb;
            b1    <= mb;
        end else if (take) begin
            state <= EMPTY;
            rcnt  <= '0;
        end else if (refresh_hit) begin
            // XORing the same value into both shares keeps the recombined operand intact.
            rcnt  <= '0;
            a0    <= a0 ^ ra;
            a1    <= a1 ^ ra;
            b0    <= b0 ^ rb;
            b1    <= b1 ^ rb;
        end else if (hold) begin
            rcnt  <= rcnt + 1'b1;
        end
    end

endmodule
